// File: rtl/connect4_turn_sequencer.sv
// Connect-4 turn controller: player move selection, validation, board write,
// win/draw resolution, turn timer control and automatic moves on timeout.
module connect4_turn_sequencer #(
  parameter int unsigned NUM_COLS  = 7,
  parameter int unsigned NUM_ROWS  = 6,
  parameter int unsigned CHECK_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          p1_col,
  input  logic                p1_valid,
  input  logic [2:0]          p2_col,
  input  logic                p2_valid,
  input  logic                timeout,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                win,
  output logic                write_en,
  output logic [2:0]          write_col,
  output logic [1:0]          write_player,
  output logic                timer_enable,
  output logic                timer_clear,
  output logic [1:0]          current_player,
  output logic [5:0]          move_count,
  output logic                reject,
  output logic                game_over,
  output logic                draw,
  output logic [1:0]          winner,
  output logic [2:0]          state
);

  localparam int unsigned LW        = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(CHECK_LAT - 1);
  localparam logic [2:0]    LAST_COL = 3'(NUM_COLS - 1);
  localparam logic [5:0]    MAX_MOVES = 6'(NUM_ROWS * NUM_COLS);
  localparam logic [1:0]    P1 = 2'b01;
  localparam logic [1:0]    P2 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_AUTO   = 3'd2,
    S_WRITE  = 3'd3,
    S_CHECK  = 3'd4,
    S_SWITCH = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        r_state;
  logic          r_p1_q, r_p2_q, r_start_q;
  logic [2:0]    r_col, r_scan;
  logic [LW-1:0] r_lat;
  logic [1:0]    r_player, r_winner;
  logic [5:0]    r_count;
  logic          r_over, r_draw, r_we, r_reject, r_ten, r_tclr;

  logic       w_p1_rise, w_p2_rise, w_req, w_col_ok, w_start_go;
  logic [2:0] w_req_col, w_scan_next;

  assign w_p1_rise  = p1_valid & ~r_p1_q;
  assign w_p2_rise  = p2_valid & ~r_p2_q;
  // Only the active player's edge counts; the other source is ignored outright.
  assign w_req      = (r_player == P1) ? w_p1_rise : w_p2_rise;
  assign w_req_col  = (r_player == P1) ? p1_col : p2_col;
  assign w_col_ok   = (w_req_col <= LAST_COL) && !col_full[w_req_col];
  assign w_start_go = (r_state == S_IDLE) ? start : (start & ~r_start_q);
  assign w_scan_next = (r_scan == LAST_COL) ? 3'd0 : r_scan + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_p1_q    <= 1'b0;
      r_p2_q    <= 1'b0;
      r_start_q <= 1'b0;
      r_col     <= '0;
      r_scan    <= '0;
      r_lat     <= '0;
      r_player  <= P1;
      r_winner  <= '0;
      r_count   <= '0;
      r_over    <= 1'b0;
      r_draw    <= 1'b0;
      r_we      <= 1'b0;
      r_reject  <= 1'b0;
      r_ten     <= 1'b0;
      r_tclr    <= 1'b1;
    end else begin
      r_p1_q    <= p1_valid;
      r_p2_q    <= p2_valid;
      r_start_q <= start;
      r_we      <= 1'b0;
      r_reject  <= 1'b0;
      r_tclr    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_ten <= 1'b0;
          if (w_start_go) begin
            r_count  <= '0;
            r_winner <= '0;
            r_over   <= 1'b0;
            r_draw   <= 1'b0;
            r_player <= P1;
            r_tclr   <= 1'b1;
            r_ten    <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_req) begin
            if (w_col_ok) begin
              r_col   <= w_req_col;
              r_we    <= 1'b1;
              r_ten   <= 1'b0;
              r_state <= S_WRITE;
            end else begin
              r_reject <= 1'b1;
            end
          end else if (timeout) begin
            r_ten   <= 1'b0;
            r_state <= S_AUTO;
          end
        end
        S_AUTO: begin
          if (!col_full[r_scan]) begin
            r_col   <= r_scan;
            r_we    <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_scan <= w_scan_next;
          end
        end
        S_WRITE: begin
          if (r_count != MAX_MOVES) r_count <= r_count + 6'd1;
          r_scan  <= (r_col == LAST_COL) ? 3'd0 : r_col + 3'd1;
          r_lat   <= '0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (r_lat == LAT_LAST) begin
            if (win) begin
              r_winner <= r_player;
              r_over   <= 1'b1;
              r_state  <= S_DONE;
            end else if (r_count == MAX_MOVES) begin
              r_draw  <= 1'b1;
              r_over  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SWITCH;
            end
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_SWITCH: begin
          r_player <= (r_player == P1) ? P2 : P1;
          r_tclr   <= 1'b1;
          r_ten    <= 1'b1;
          r_state  <= S_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign write_en       = r_we;
  assign write_col      = r_col;
  assign write_player   = r_player;
  assign timer_enable   = r_ten;
  assign timer_clear    = r_tclr;
  assign current_player = r_player;
  assign move_count     = r_count;
  assign reject         = r_reject;
  assign game_over      = r_over;
  assign draw           = r_draw;
  assign winner         = r_winner;
  assign state          = r_state;

endmodule

// File: tb/tb_connect4_turn_sequencer.sv
// Scoreboard bench for connect4_turn_sequencer: expected writes/rejects are
// queued by the stimulus from a game-level model and popped by a monitor.
module tb_connect4_turn_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd6;

  logic       clk, reset, start, p1_valid, p2_valid, timeout, win;
  logic [2:0] p1_col, p2_col;
  logic [6:0] col_full;
  logic       write_en, timer_enable, timer_clear, reject, game_over, draw;
  logic [2:0] write_col, state;
  logic [1:0] write_player, current_player, winner;
  logic [5:0] move_count;

  connect4_turn_sequencer #(.NUM_COLS(7), .NUM_ROWS(6), .CHECK_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .p1_col(p1_col), .p1_valid(p1_valid), .p2_col(p2_col), .p2_valid(p2_valid),
    .timeout(timeout), .col_full(col_full), .win(win),
    .write_en(write_en), .write_col(write_col), .write_player(write_player),
    .timer_enable(timer_enable), .timer_clear(timer_clear),
    .current_player(current_player), .move_count(move_count), .reject(reject),
    .game_over(game_over), .draw(draw), .winner(winner), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int q_col[$];
  int q_ply[$];
  int q_rej[$];

  // Game-level reference model
  int m_player, m_count, m_scan, m_winner, m_over, m_draw;
  int heights[7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (write_en) begin
        if (q_col.size() == 0) chk("unexpected_write", int'(write_en), 0);
        else begin
          chk("write_col", int'(write_col), q_col.pop_front());
          chk("write_player", int'(write_player), q_ply.pop_front());
          chk("write_state", int'(state), int'(ST_WRITE));
        end
      end
      if (reject) begin
        if (q_rej.size() == 0) chk("unexpected_reject", int'(reject), 0);
        else chk("reject_player", int'(current_player), q_rej.pop_front());
      end
    end
  end

  function automatic bit in_mode(input int mode);
    case (mode)
      0:       return state == ST_WRITE;
      1:       return (state == ST_WAIT) || (state == ST_DONE);
      default: return state != ST_WAIT;
    endcase
  endfunction

  task automatic wait_for(input int mode, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      ok = in_mode(mode);
      if (ok) break;
      tick();
    end
    chk(name, int'(ok), 1);
  endtask

  function automatic logic [6:0] full_mask();
    logic [6:0] m = '0;
    for (int c = 0; c < 7; c++) m[c] = (heights[c] >= 6);
    return m;
  endfunction

  function automatic int pick_col();
    int c = $urandom_range(0, 6);
    for (int k = 0; k < 7; k++)
      if (heights[(c + k) % 7] < 6) return (c + k) % 7;
    return 0;
  endfunction

  function automatic int pick_bad();
    int c = $urandom_range(0, 6);
    if ($urandom_range(0, 1) == 0) return 7;
    for (int k = 0; k < 7; k++)
      if (col_full[(c + k) % 7]) return (c + k) % 7;
    return 7;
  endfunction

  task automatic check_model();
    chk("current_player", int'(current_player), m_player);
    chk("move_count", int'(move_count), m_count);
    chk("game_over", int'(game_over), m_over);
    chk("draw", int'(draw), m_draw);
    chk("winner", int'(winner), m_winner);
  endtask

  task automatic check_reset();
    chk("rst_state", int'(state), int'(ST_IDLE));
    chk("rst_player", int'(current_player), 1);
    chk("rst_count", int'(move_count), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_draw", int'(draw), 0);
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_timer_en", int'(timer_enable), 0);
    chk("rst_timer_clr", int'(timer_clear), 1);
  endtask

  task automatic model_clear();
    m_player = 1; m_count = 0; m_winner = 0; m_over = 0; m_draw = 0;
    for (int c = 0; c < 7; c++) heights[c] = 0;
    col_full = '0;
  endtask

  task automatic new_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    chk("ng_state", int'(state), int'(ST_WAIT));
    chk("ng_timer_clr", int'(timer_clear), 1);
    chk("ng_timer_en", int'(timer_enable), 1);
    check_model();
  endtask

  task automatic press(input int who, input int col, input int hold);
    if (who == 1) begin p1_col = 3'(col); p1_valid = 1'b1; end
    else begin p2_col = 3'(col); p2_valid = 1'b1; end
    for (int i = 0; i < hold; i++) tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    tick();
  endtask

  task automatic invalid_press(input int col, input int hold);
    q_rej.push_back(m_player);
    press(m_player, col, hold);
    chk("rej_state", int'(state), int'(ST_WAIT));
    chk("rej_count", int'(move_count), m_count);
  endtask

  // kind 0: player request on col; kind 1: timer expiry, automatic column
  task automatic turn(input int kind, input int col, input bit wn);
    int ec = col;
    if (kind == 1) begin
      for (int k = 6; k >= 0; k--)
        if (!col_full[(m_scan + k) % 7]) ec = (m_scan + k) % 7;
    end
    q_col.push_back(ec);
    q_ply.push_back(m_player);
    win = wn;
    if (kind == 1) begin
      timeout = 1'b1;
      wait_for(2, 5, "enter_auto");
      timeout = 1'b0;
      chk("auto_timer_en", int'(timer_enable), 0);
    end else if (m_player == 1) begin
      p1_col = 3'(col); p1_valid = 1'b1;
    end else begin
      p2_col = 3'(col); p2_valid = 1'b1;
    end
    wait_for(0, 10, "reach_write");
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    wait_for(1, 10, "turn_end");
    win = 1'b0;
    m_count++;
    m_scan = (ec + 1) % 7;
    heights[ec]++;
    if (wn) begin m_winner = m_player; m_over = 1; end
    else if (m_count == 42) begin m_draw = 1; m_over = 1; end
    else m_player = 3 - m_player;
    col_full = full_mask();
    check_model();
    chk("turn_state", int'(state), m_over ? int'(ST_DONE) : int'(ST_WAIT));
  endtask

  task automatic random_turn();
    turn(($urandom_range(0, 3) == 0) ? 1 : 0, pick_col(), 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
    p1_col = '0; p2_col = '0; timeout = 1'b0; win = 1'b0; col_full = '0;
    m_scan = 0;
    model_clear();
    tick(); tick();
    check_reset();
    reset = 1'b0;
    tick();
    chk("idle_state", int'(state), int'(ST_IDLE));
    chk("idle_timer_en", int'(timer_enable), 0);
    new_game();

    // Test 1: held button gives one write; handover after 1+CHECK_LAT+2 cycles
    q_col.push_back(3); q_ply.push_back(1);
    p1_col = 3'd3; p1_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t1_player_early", int'(current_player), 1);
    tick();
    p1_valid = 1'b0;
    chk("t1_player", int'(current_player), 2);
    chk("t1_state", int'(state), int'(ST_WAIT));
    chk("t1_timer_clr", int'(timer_clear), 1);
    tick();
    chk("t1_timer_clr_pulse", int'(timer_clear), 0);
    m_count = 1; m_scan = 4; heights[3] = 1; m_player = 2;
    check_model();

    // Test 2: player 1 edges ignored, column 7 from player 2 rejected once
    for (int i = 0; i < 3; i++) press(1, pick_col(), 1);
    invalid_press(7, 4);

    for (int i = 0; i < 4; i++) random_turn();

    // Test 3: automatic move scans past full columns from the scan pointer
    turn(0, 1, 1'b0);
    col_full = 7'b0011111;
    turn(1, 0, 1'b0);
    col_full = 7'b0011110;
    turn(1, 0, 1'b0);
    for (int i = 0; i < 3; i++) random_turn();

    // Test 4: player 2 wins; DONE ignores presses and timeouts
    if (m_player == 1) random_turn();
    turn(0, pick_col(), 1'b1);
    press(1, pick_col(), 2);
    press(2, pick_col(), 2);
    timeout = 1'b1; tick(); tick(); timeout = 1'b0; tick();
    chk("t4_done_state", int'(state), int'(ST_DONE));
    check_model();

    // Test 5: full board without a winner is a draw
    new_game();
    for (int i = 0; i < 42; i++) begin
      if ($urandom_range(0, 3) == 0) press(3 - m_player, pick_col(), 1);
      if ($urandom_range(0, 3) == 0) invalid_press(pick_bad(), 2);
      random_turn();
    end
    chk("t5_count", int'(move_count), 42);
    new_game();

    // Test 6: reset during WRITE aborts immediately
    q_col.push_back(pick_col()); q_ply.push_back(1);
    p1_col = 3'(q_col[0]); p1_valid = 1'b1;
    wait_for(0, 5, "t6_reach_write");
    chk("t6_write_seen", int'(write_en), 1);
    #1 reset = 1'b1;
    #1 check_reset();
    q_col.delete(); q_ply.delete();
    p1_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_scan = 0;
    tick();
    new_game();
    turn(1, 0, 1'b0);
    turn(0, pick_col(), 1'b0);

    tick(); tick();
    chk("write_queue_empty", q_col.size(), 0);
    chk("reject_queue_empty", q_rej.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/connect4_turn_sequencer.md
Name: connect4_turn_sequencer

Overview:
Central turn controller for the Connect-4 game datapath. Each turn it:
- selects the active player's move source: FPGA switches/button for player 1, Arduino for player 2;
- validates the move against the column-full mask;
- issues a single-cycle write to the board;
- waits for the win detector, then either ends the game or hands the turn over.

It drives the 10 s turn timer and substitutes an automatic move when the timer expires. It replaces the ad-hoc turn FSM and player-select logic in the top level.

Parameters:
- NUM_COLS, 7, number of board columns (the column index is 3 bits wide).
- NUM_ROWS, 6, number of board rows; the board holds NUM_ROWS*NUM_COLS = 42 cells.
- CHECK_LAT, 2, cycles to wait after a write before sampling win (covers board register plus detector).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begins a new game from IDLE
- p1_col  in  3  player 1 column (switches)
- p1_valid  in  1  player 1 confirm (level, already active-high)
- p2_col  in  3  player 2 column (Arduino)
- p2_valid  in  1  player 2 confirm (level)
- timeout  in  1  turn timer expired (level)
- col_full  in  7  bit c = 1 when column c is full
- win  in  1  detector reports four-in-a-row
- write_en  out  1  one-cycle board write strobe
- write_col  out  3  column for the write
- write_player  out  2  piece code: 01 = player 1, 10 = player 2
- timer_enable  out  1  turn timer runs
- timer_clear  out  1  one-cycle timer restart
- current_player  out  2  01 or 10
- move_count  out  6  pieces placed, 0..42
- reject  out  1  one-cycle pulse: invalid move ignored
- game_over  out  1  sticky until new game
- draw  out  1  sticky: board filled with no winner
- winner  out  2  00 none, 01 or 10
- state  out  3  encoded FSM state for debug/VGA

Behaviour:
Reset (asynchronous, all registers):
- state = IDLE, current_player = 01, move_count = 0, winner = 00.
- game_over, draw, write_en, reject, timer_enable = 0; timer_clear = 1 while in reset.
- Edge-detect registers = 0; scan pointer = 0.

Move edge detection:
- p1_valid and p2_valid each pass through a one-flop rising-edge detector.
- A move request is the edge of the current player's source only. The other player's edges are discarded, never queued.
- Holding the button generates exactly one request.

States and transitions:
- IDLE: timer_enable = 0. When start = 1, clear move_count, winner, game_over and draw; set current_player = 01; pulse timer_clear; go to WAIT.
- WAIT: timer_enable = 1.
  - Move request with col < NUM_COLS and col_full[col] = 0: latch the column and go to WRITE.
  - Move request with col >= 7 or a full column: reject = 1 for one cycle; stay in WAIT. The timer is not restarted.
  - timeout = 1 with no request: go to AUTO.
  - Request and timeout in the same cycle: the request wins.
- AUTO: timer_enable = 0. Scan one column per cycle, starting at the scan pointer and wrapping 6 -> 0.
  - First column with col_full = 0 is latched; go to WRITE.
  - Worst case is 7 cycles. The scan always finds a column because move_count < 42 in this state.
- WRITE: write_en = 1 for exactly one cycle, with write_col = latched column and write_player = current_player. Then move_count increments, the scan pointer is set to (column + 1) mod 7, and the FSM goes to CHECK.
- CHECK: wait CHECK_LAT cycles, then sample win.
  - win = 1: winner = current_player; game_over = 1; go to DONE.
  - Otherwise, move_count = 42: draw = 1; game_over = 1; go to DONE.
  - Otherwise go to SWITCH.
- SWITCH: toggle current_player; pulse timer_clear; go to WAIT.
  - Request latency: 1 + CHECK_LAT + 2 cycles from the detected request to the next WAIT.
- DONE: timer_enable = 0; all outputs hold. A start rising edge behaves as in IDLE and begins a new game.
  - The board itself is cleared by the system reset. A new game via start does not clear the board; this is documented and is the top level's job.

Other rules:
- write_en never asserts outside WRITE, and at most once per turn.
- move_count saturates at 42.
- Inputs are not sampled in WRITE, CHECK or SWITCH. Edges arriving in those states are lost by design.
- Reset mid-turn (including during WRITE) aborts immediately. There is no partial write beyond the cycle in which reset asserts.

Test Plan:
1. Reset, then start; player 1 picks col 3 and presses p1_valid for 5 cycles -> exactly one write_en with col 3, player 01; current_player becomes 10 after 1+CHECK_LAT+2 cycles; one timer_clear pulse.
2. Player 2 is current; p1_valid toggles; p2_col = 7 is pressed -> no write and no reject for p1; a single reject pulse for the col-7 press; state stays WAIT.
3. col_full = 7'b0011111, last write was col 1, timeout asserts -> AUTO scans 2, 3, 4 (full) and then 5; write_col = 5; the scan pointer then becomes 6.
4. Force win = 1 during CHECK after a player 2 write -> winner = 10, game_over = 1, state DONE; later p1/p2 presses and timeout cause no write.
5. Play 42 alternating valid moves with win held 0 -> draw = 1, move_count = 42, game_over = 1; start then clears all of them and current_player = 01.
6. Assert reset while in WRITE -> write_en drops asynchronously; all outputs take reset values; start resumes a normal game.
